hamming84_serial_decoder: RTL and testbench
===========================================

// Module: hamming84_serial_decoder
// PURPOSE
//  Downstream consumer of the 4-bit universal register's serial_out stream.
//  - Deserialises 8-bit Hamming(8,4) SECDED codewords.
//  - Corrects single-bit errors and flags double-bit errors.
//  - Presents the 4-bit payload on a valid/ready interface.
//  - Keeps saturating counts of corrected and uncorrectable frames.
// PARAMETERS
//  CNT_W      8   width of corr_cnt / dbl_cnt (saturating)
//  MSB_FIRST  1   1: first serial bit is c[7]; 0: first serial bit is c[0]
// PORTS
//  clk            in   1      single clock; all flops on posedge
//  rst            in   1      asynchronous, active-low reset
//  enable         in   1      bit strobe; serial_in/sync sampled only when 1
//  sync           in   1      frame start, coincident with first codeword bit
//  serial_in      in   1      serial codeword bit
//  clr_cnt        in   1      synchronous clear of both counters
//  out_ready      in   1      sink accepts out_data
//  out_valid      out  1      decoded nibble available
//  out_data       out  4      corrected payload {c7,c6,c5,c3}
//  out_single_err out  1      frame had a corrected 1-bit error (qualified by out_valid)
//  out_double_err out  1      frame had an uncorrectable error (qualified by out_valid)
//  out_syndrome   out  3      {s4,s2,s1} of the frame (qualified by out_valid)
//  overrun        out  1      1-cycle pulse: frame start dropped
//  busy           out  1      state != IDLE
//  corr_cnt       out  CNT_W  corrected-frame count
//  dbl_cnt        out  CNT_W  double-error-frame count
// BEHAVIOUR
//  Codeword layout
//  - c[1]=p1, c[2]=p2, c[3]=d0, c[4]=p4, c[5]=d1, c[6]=d2, c[7]=d3.
//  - c[0]=p0 is even parity over c[7:1].
//  - s1=^c{1,3,5,7}; s2=^c{2,3,6,7}; s4=^c{4,5,6,7}; P=^c[7:0].
//  Decode
//  - s==0, P==0: clean.
//  - s!=0, P==1: flip c[s]; single_err.
//  - s==0, P==1: p0 is in error, data unchanged; single_err.
//  - s!=0, P==0: double_err; data passes through uncorrected.
//  Reset
//  - State IDLE; every output, counter and the shift register is 0.
//  FSM: IDLE -> SHIFT -> DECODE -> OUT
//  - IDLE: enable&sync captures the current serial_in as bit 1, bit count = 1, go to SHIFT.
//  - SHIFT: each enable=1 cycle captures one bit. enable=0 holds state and count (gaps allowed).
//  - SHIFT: enable&sync restarts the frame; that bit becomes bit 1 and count = 1. No error flag.
//  - SHIFT: once the 8th bit is captured, go to DECODE.
//  - DECODE (1 cycle): register out_* and update counters; out_valid=1 at the next edge; go to OUT.
//  - Latency: 8th bit sampled at edge N gives out_valid=1 after edge N+1.
//  - OUT: out_data and flags are held stable while out_valid&!out_ready.
//  - OUT: out_valid&out_ready clears out_valid and returns to IDLE.
//  - OUT: if enable&sync occurs in the same cycle as the handshake, go straight to SHIFT (count = 1).
//    Back-to-back frames are allowed.
//  - OUT: enable&sync without a handshake pulses overrun for 1 cycle. The frame is dropped.
//    Outputs and state stay unchanged.
//  Counters
//  - Increment once per decoded frame, in DECODE.
//  - Saturate at all-ones.
//  - clr_cnt has priority over an increment in the same cycle.
//  Asynchronous reset mid-frame
//  - Discards any partial frame or pending output immediately.
// TESTING
//  Clean frame 0xAA with enable gaps inserted
//  - Expect out_data=4'b1011, syndrome 0, both error flags 0.
//  - out_valid rises 2 edges after the last bit.
//  Single error: send 0x8A (c5 flipped)
//  - Expect out_data=4'b1011, single_err=1, syndrome=3'b101, corr_cnt=1.
//  Double error: send 0xCA (c5 and c6 flipped)
//  - Expect double_err=1, syndrome=3'b011, out_data=4'b1101, dbl_cnt=1.
//  Parity-bit error: send 0xAB
//  - Expect single_err=1, syndrome=0, out_data=4'b1011.
//  Backpressure: hold out_ready=0, then send a new sync
//  - Expect an overrun pulse and out_data held.
//  - Then raise out_ready together with sync: the new frame decodes.
//  Reset mid-frame: assert rst low after 4 bits
//  - Expect busy=0 and counters=0; the next full 0xAA frame decodes cleanly.

Source files
------------

// File: rtl/hamming84_serial_decoder.sv
// Serial Hamming(8,4) SECDED decoder: deserialises codewords, corrects single-bit errors,
// flags double-bit errors and presents the payload on a valid/ready interface.
module hamming84_serial_decoder #(
    parameter int CNT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sync,
    input  logic             serial_in,
    input  logic             clr_cnt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             out_single_err,
    output logic             out_double_err,
    output logic [2:0]       out_syndrome,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] dbl_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, OUT} state_e;

    state_e           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       data_q, data_d;
    logic             serr_q, serr_d;
    logic             derr_q, derr_d;
    logic [2:0]       syn_q, syn_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] dbl_q, dbl_d;

    logic       start;
    logic [7:0] sr_first, sr_shift;
    logic [2:0] syn;
    logic       par;
    logic [7:0] flip, cw_fix;

    assign start = enable & sync;

    // A new frame discards whatever was in the register, so bit 1 goes into a cleared word.
    assign sr_first = MSB_FIRST ? {7'b0, serial_in} : {serial_in, 7'b0};
    assign sr_shift = MSB_FIRST ? {sr_q[6:0], serial_in} : {serial_in, sr_q[7:1]};

    assign syn = {^{sr_q[4], sr_q[5], sr_q[6], sr_q[7]},
                  ^{sr_q[2], sr_q[3], sr_q[6], sr_q[7]},
                  ^{sr_q[1], sr_q[3], sr_q[5], sr_q[7]}};
    assign par = ^sr_q;

    always_comb begin
        flip = '0;
        if (par && syn != 3'd0) flip[syn] = 1'b1;
    end
    assign cw_fix = sr_q ^ flip;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        serr_d  = serr_q;
        derr_d  = derr_q;
        syn_d   = syn_q;
        ovr_d   = 1'b0;
        corr_d  = corr_q;
        dbl_d   = dbl_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = sr_first;
                    cnt_d   = 3'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    sr_d  = sr_first;
                    cnt_d = 3'd1;
                end else if (enable) begin
                    sr_d = sr_shift;
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = DECODE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DECODE: begin
                valid_d = 1'b1;
                data_d  = {cw_fix[7], cw_fix[6], cw_fix[5], cw_fix[3]};
                serr_d  = par;
                derr_d  = !par && (syn != 3'd0);
                syn_d   = syn;
                if (par && corr_q != '1) corr_d = corr_q + 1'b1;
                if (!par && syn != 3'd0 && dbl_q != '1) dbl_d = dbl_q + 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        sr_d    = sr_first;
                        cnt_d   = 3'd1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_cnt) begin
            corr_d = '0;
            dbl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            serr_q  <= 1'b0;
            derr_q  <= 1'b0;
            syn_q   <= '0;
            ovr_q   <= 1'b0;
            corr_q  <= '0;
            dbl_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            serr_q  <= serr_d;
            derr_q  <= derr_d;
            syn_q   <= syn_d;
            ovr_q   <= ovr_d;
            corr_q  <= corr_d;
            dbl_q   <= dbl_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_data       = data_q;
    assign out_single_err = serr_q;
    assign out_double_err = derr_q;
    assign out_syndrome   = syn_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q != IDLE);
    assign corr_cnt       = corr_q;
    assign dbl_cnt        = dbl_q;

endmodule

// File: tb/tb_hamming84_serial_decoder.sv
// Bench for hamming84_serial_decoder: directed frames plus random bit streams checked
// every cycle against a frame-level model of the decoder.
module tb_hamming84_serial_decoder;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic enable = 1'b0, sync = 1'b0, serial_in = 1'b0, clr_cnt = 1'b0, out_ready = 1'b0;
    logic             out_valid, out_single_err, out_double_err, overrun, busy;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic [CNT_W-1:0] corr_cnt, dbl_cnt;

    hamming84_serial_decoder #(.CNT_W(CNT_W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst_n), .enable(enable), .sync(sync), .serial_in(serial_in),
        .clr_cnt(clr_cnt), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_single_err(out_single_err), .out_double_err(out_double_err),
        .out_syndrome(out_syndrome), .overrun(overrun), .busy(busy),
        .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decode from first principles: syndrome is the XOR of the positions of all set bits
    // in c[7:1]; overall parity decides single vs double. Returns {data, single, double, syn}.
    function automatic logic [8:0] ref_dec(input logic [7:0] c);
        int s = 0;
        int p = $countones(c) % 2;
        logic [7:0] cc = c;
        logic [2:0] s3;
        for (int i = 1; i < 8; i++) if (c[i]) s = s ^ i;
        s3 = s[2:0];
        if (p == 1 && s != 0) cc[s] = ~cc[s];
        return {cc[7], cc[6], cc[5], cc[3], (p == 1), (p == 0 && s != 0), s3};
    endfunction

    // Frame-level model: bits collected into a word, then one decode cycle, then a held output.
    int         m_n;
    bit         m_coll, m_dec, m_out;
    logic [7:0] m_cw;
    logic [8:0] e_res;
    bit         e_valid, e_ovr;
    int         e_corr, e_dbl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_coll = 0; m_dec = 0; m_out = 0; m_cw = '0;
            e_res = '0; e_valid = 0; e_ovr = 0; e_corr = 0; e_dbl = 0;
        end else begin
            e_ovr = 0;
            if (m_dec) begin
                e_res = ref_dec(m_cw);
                e_valid = 1; m_dec = 0; m_out = 1;
                if (e_res[4] && e_corr < CNT_MAX) e_corr++;
                if (e_res[3] && e_dbl < CNT_MAX) e_dbl++;
            end else if (m_out) begin
                if (out_ready) begin
                    e_valid = 0; m_out = 0;
                    if (enable && sync) begin
                        m_coll = 1; m_cw = '0; m_cw[7] = serial_in; m_n = 1;
                    end
                end else if (enable && sync) begin
                    e_ovr = 1;
                end
            end else if (enable) begin
                if (sync) begin
                    m_coll = 1; m_cw = '0; m_cw[7] = serial_in; m_n = 1;
                end else if (m_coll) begin
                    m_cw[7-m_n] = serial_in;
                    m_n++;
                    if (m_n == 8) begin m_coll = 0; m_dec = 1; end
                end
            end
            if (clr_cnt) begin e_corr = 0; e_dbl = 0; end
        end
    end

    always @(posedge clk) begin
        #2;
        cmp("busy", busy, m_coll | m_dec | m_out);
        cmp("out_valid", out_valid, e_valid);
        cmp("overrun", overrun, e_ovr);
        cmp("corr_cnt", corr_cnt, e_corr);
        cmp("dbl_cnt", dbl_cnt, e_dbl);
        if (e_valid) begin
            cmp("out_data", out_data, e_res[8:5]);
            cmp("out_single_err", out_single_err, e_res[4]);
            cmp("out_double_err", out_double_err, e_res[3]);
            cmp("out_syndrome", out_syndrome, e_res[2:0]);
        end
    end

    task automatic tick(input logic en, input logic sy, input logic sin, input logic rdy,
                        input logic clr = 1'b0);
        enable = en; sync = sy; serial_in = sin; out_ready = rdy; clr_cnt = clr;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cw, input bit gaps, input logic rdy);
        for (int i = 0; i < 8; i++) begin
            if (gaps && ($urandom % 2 == 0)) tick(1'b0, 1'b0, 1'b0, rdy);
            tick(1'b1, (i == 0), cw[7-i], rdy);
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 6) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        cmp("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic check_out(input string nm, input logic [3:0] d, input logic se,
                             input logic de, input logic [2:0] sy);
        cmp({nm, "_data"}, out_data, d);
        cmp({nm, "_serr"}, out_single_err, se);
        cmp({nm, "_derr"}, out_double_err, de);
        cmp({nm, "_syn"}, out_syndrome, sy);
    endtask

    initial begin
        cmp("pin_AA", ref_dec(8'hAA), {4'b1011, 1'b0, 1'b0, 3'b000});
        cmp("pin_8A", ref_dec(8'h8A), {4'b1011, 1'b1, 1'b0, 3'b101});
        cmp("pin_CA", ref_dec(8'hCA), {4'b1101, 1'b0, 1'b1, 3'b011});
        cmp("pin_AB", ref_dec(8'hAB), {4'b1011, 1'b1, 1'b0, 3'b000});

        repeat (3) @(negedge clk);
        cmp("rst_busy", busy, 0);
        cmp("rst_valid", out_valid, 0);
        cmp("rst_corr", corr_cnt, 0);
        cmp("rst_dbl", dbl_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(8'hAA, 1, 1'b0);
        wait_valid();
        check_out("clean", 4'b1011, 0, 0, 3'b000);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'h8A, 0, 1'b0);
        wait_valid();
        check_out("single", 4'b1011, 1, 0, 3'b101);
        cmp("single_corr", corr_cnt, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'hCA, 1, 1'b0);
        wait_valid();
        check_out("double", 4'b1101, 0, 1, 3'b011);
        cmp("double_dbl", dbl_cnt, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'hAB, 0, 1'b0);
        wait_valid();
        check_out("p0err", 4'b1011, 1, 0, 3'b000);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: a sync while the output is held is dropped with an overrun pulse.
        send_frame(8'hAA, 0, 1'b0);
        wait_valid();
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        cmp("bp_overrun", overrun, 1);
        cmp("bp_valid", out_valid, 1);
        cmp("bp_data", out_data, 4'b1011);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("bp_overrun_pulse", overrun, 0);
        send_frame(8'h8A, 0, 1'b1);
        wait_valid();
        check_out("bp_next", 4'b1011, 1, 0, 3'b101);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) tick(1'b1, (i == 0), 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_busy", busy, 0);
        cmp("midrst_corr", corr_cnt, 0);
        cmp("midrst_dbl", dbl_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'hAA, 0, 1'b0);
        wait_valid();
        check_out("post_rst", 4'b1011, 0, 0, 3'b000);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4000; i++)
            tick(($urandom % 4) != 0, ($urandom % 10) == 0, $urandom % 2,
                 ($urandom % 3) != 0, ($urandom % 300) == 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
